rs232_tx: RTL and testbench

RS232_TX -- requirements
Module: rs232_tx

---
 rtl/rs232_tx_if.sv | 11 +
 rtl/rs232_tx.sv | 165 ++++++++++++++++
 tb/tb_rs232_tx.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rs232_tx_if.sv
// Byte-write port of the serial transmitter: write strobe and data in,
// FIFO-full and transmitter-idle status out.
interface rs232_tx_if;
  logic       w;
  logic [7:0] d;
  logic       busy;
  logic       idle;

  modport master (output w, d, input busy, idle);
  modport slave  (input w, d, output busy, idle);
endinterface

// File: rtl/rs232_tx.sv
// 8N1 serial transmitter fed by a DEPTH-entry byte FIFO; frames leave back to
// back with no idle gap while bytes are queued.
module rs232_tx #(
  parameter int BAUD_DIV   = 434,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic      clk,
  input  logic      rst,
  rs232_tx_if.slave bus,
  output logic      txd
);
  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam int CNT_W = DEPTH_LOG2 + 1;
  localparam logic [CNT_W-1:0]      CNT_FULL    = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]      CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0]      CNT_ZERO    = CNT_W'(0);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE     = DEPTH_LOG2'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ZERO    = DEPTH_LOG2'(0);
  localparam logic [15:0]           BAUD_RELOAD = 16'(BAUD_DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  logic [7:0]            mem_r [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_r;
  logic [DEPTH_LOG2-1:0] rd_ptr_r;
  logic [CNT_W-1:0]      count_r;
  state_t                state_r;
  state_t                state_s;
  logic [15:0]           baud_cnt_r;
  logic [15:0]           baud_cnt_s;
  logic [2:0]            bit_idx_r;
  logic [2:0]            bit_idx_s;
  logic [7:0]            shift_r;
  logic [7:0]            shift_s;
  logic                  txd_r;
  logic                  txd_s;
  logic                  push_s;
  logic                  pop_s;
  logic                  fifo_empty_s;
  logic                  bit_end_s;

  // Next-state, line value and FIFO push/pop decode for the transmitter
  always_comb begin
    fifo_empty_s = (count_r == CNT_ZERO);
    // Fullness comes from the registered count, so a same-cycle pop never frees a slot
    push_s       = bus.w && (count_r != CNT_FULL);
    bit_end_s    = (baud_cnt_r == 16'd0);
    pop_s        = 1'b0;
    state_s      = state_r;
    bit_idx_s    = bit_idx_r;
    shift_s      = shift_r;
    txd_s        = txd_r;
    if (bit_end_s) begin
      baud_cnt_s = 16'd0;
    end else begin
      baud_cnt_s = baud_cnt_r - 16'd1;
    end

    case (state_r)
      IDLE: begin
        if (!fifo_empty_s) begin
          pop_s      = 1'b1;
          shift_s    = mem_r[rd_ptr_r];
          baud_cnt_s = BAUD_RELOAD;
          txd_s      = 1'b0;
          state_s    = START;
        end else begin
          txd_s      = 1'b1;
        end
      end
      START: begin
        if (bit_end_s) begin
          txd_s      = shift_r[0];
          bit_idx_s  = 3'd0;
          baud_cnt_s = BAUD_RELOAD;
          state_s    = DATA;
        end else begin
          txd_s      = 1'b0;
        end
      end
      DATA: begin
        if (bit_end_s) begin
          baud_cnt_s = BAUD_RELOAD;
          if (bit_idx_r != 3'd7) begin
            shift_s   = {1'b0, shift_r[7:1]};
            bit_idx_s = bit_idx_r + 3'd1;
            txd_s     = shift_r[1];
          end else begin
            txd_s     = 1'b1;
            state_s   = STOP;
          end
        end else begin
          txd_s = shift_r[0];
        end
      end
      STOP: begin
        if (bit_end_s) begin
          if (!fifo_empty_s) begin
            pop_s      = 1'b1;
            shift_s    = mem_r[rd_ptr_r];
            baud_cnt_s = BAUD_RELOAD;
            txd_s      = 1'b0;
            state_s    = START;
          end else begin
            txd_s      = 1'b1;
            state_s    = IDLE;
          end
        end else begin
          txd_s = 1'b1;
        end
      end
      default: begin
        txd_s   = 1'b1;
        state_s = IDLE;
      end
    endcase
  end

  // Transmitter registers and FIFO pointers/count
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      txd_r      <= 1'b1;
      count_r    <= CNT_ZERO;
      wr_ptr_r   <= PTR_ZERO;
      rd_ptr_r   <= PTR_ZERO;
      baud_cnt_r <= 16'd0;
      bit_idx_r  <= 3'd0;
      shift_r    <= 8'd0;
    end else begin
      state_r    <= state_s;
      txd_r      <= txd_s;
      baud_cnt_r <= baud_cnt_s;
      bit_idx_r  <= bit_idx_s;
      shift_r    <= shift_s;
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // FIFO storage; validity is tracked by pointers and count only
  always_ff @(posedge clk) begin
    if (push_s && !rst) begin
      mem_r[wr_ptr_r] <= bus.d;
    end
  end

  assign txd      = txd_r;
  assign bus.busy = (count_r == CNT_FULL);
  assign bus.idle = (state_r == IDLE) && (count_r == CNT_ZERO);
endmodule

// File: tb/tb_rs232_tx.sv
// Self-checking bench for rs232_tx: cycle-exact line checks plus a UART-decode
// scoreboard on two instances (BAUD_DIV=4/DEPTH 4 and BAUD_DIV=2/DEPTH 16).
module tb_rs232_tx;
  logic clk;
  logic rst;
  logic txd_a;
  logic txd_b;
  int   cyc = 0;
  int   n_cmp;
  int   n_err;
  int   frame_err;
  logic [7:0] exp_a[$];
  logic [7:0] exp_b[$];
  logic [7:0] rx_a[$];
  logic [7:0] rx_b[$];
  int         starts_a[$];

  rs232_tx_if bus_a ();
  rs232_tx_if bus_b ();

  rs232_tx #(.BAUD_DIV(4), .DEPTH_LOG2(2)) dut_a (.clk(clk), .rst(rst), .bus(bus_a), .txd(txd_a));
  rs232_tx #(.BAUD_DIV(2), .DEPTH_LOG2(4)) dut_b (.clk(clk), .rst(rst), .bus(bus_b), .txd(txd_b));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic line_of(input int sel);
    return (sel == 0) ? txd_a : txd_b;
  endfunction

  // UART receiver: samples each bit in its middle and queues the decoded byte
  task automatic rx_line(input int sel, input int b);
    logic [7:0] v;
    logic       ok;
    int         s;
    forever begin
      @(negedge clk);
      if (line_of(sel) === 1'b0) begin
        s = cyc;
        repeat (b / 2) @(negedge clk);
        ok = (line_of(sel) === 1'b0);
        for (int i = 0; i < 8; i++) begin
          repeat (b) @(negedge clk);
          v[i] = line_of(sel);
        end
        repeat (b) @(negedge clk);
        ok = ok && (line_of(sel) === 1'b1);
        if (!ok) frame_err++;
        if (sel == 0) begin
          rx_a.push_back(v);
          starts_a.push_back(s);
        end else begin
          rx_b.push_back(v);
        end
      end
    end
  endtask

  task automatic wait_idle(input int sel, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (((sel == 0) ? bus_a.idle : bus_b.idle) === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus_a.w = 1'b1; bus_a.d = 8'hAA;
    bus_b.w = 1'b1; bus_b.d = 8'h5A;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0; bus_a.w = 1'b0; bus_b.w = 1'b0;
    @(negedge clk);
    n_cmp++; if (txd_a !== 1'b1) begin n_err++; $display("FAIL reset_txd_a: got %b expected 1", txd_a); end
    n_cmp++; if (bus_a.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy_a: got %b expected 0", bus_a.busy); end
    n_cmp++; if (bus_a.idle !== 1'b1) begin n_err++; $display("FAIL reset_idle_a: got %b expected 1", bus_a.idle); end
    n_cmp++; if (txd_b !== 1'b1) begin n_err++; $display("FAIL reset_txd_b: got %b expected 1", txd_b); end
    n_cmp++; if (bus_b.idle !== 1'b1) begin n_err++; $display("FAIL reset_idle_b: got %b expected 1", bus_b.idle); end
    repeat (10) @(negedge clk);
    n_cmp++; if (bus_a.idle !== 1'b1 || txd_a !== 1'b1) begin n_err++; $display("FAIL reset_write_ignored: got idle=%b txd=%b expected 1 1", bus_a.idle, txd_a); end
  endtask

  task automatic test_single;
    logic [7:0] pat;
    logic [7:0] g;
    logic       e;
    bit         ok;
    pat = 8'h55;
    exp_a.push_back(pat);
    @(posedge clk); #1;
    bus_a.w = 1'b1; bus_a.d = pat;
    for (int n = 0; n <= 42; n++) begin
      @(negedge clk);
      if (n < 2 || n >= 38) e = 1'b1;
      else if (n < 6) e = 1'b0;
      else e = pat[(n - 6) / 4];
      n_cmp++; if (txd_a !== e) begin n_err++; $display("FAIL single_txd c%0d: got %b expected %b", n, txd_a, e); end
      if (n == 1 || n == 41 || n == 42) begin
        n_cmp++; if (bus_a.idle !== (n == 42)) begin n_err++; $display("FAIL single_idle c%0d: got %b expected %b", n, bus_a.idle, (n == 42)); end
      end
      @(posedge clk); #1;
      bus_a.w = 1'b0;
    end
    wait_idle(0, 100, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL single_timeout: got busy line expected idle"); end
    n_cmp++; if (rx_a.size() != exp_a.size()) begin n_err++; $display("FAIL single_count: got %0d frames expected %0d", rx_a.size(), exp_a.size()); end
    while (rx_a.size() > 0 && exp_a.size() > 0) begin
      g = rx_a.pop_front(); pat = exp_a.pop_front();
      n_cmp++; if (g !== pat) begin n_err++; $display("FAIL single_byte: got %h expected %h", g, pat); end
    end
    rx_a.delete(); exp_a.delete();
  endtask

  task automatic test_back_to_back;
    logic [7:0] g;
    logic [7:0] e;
    int         w0;
    bit         ok;
    starts_a.delete();
    exp_a.push_back(8'hA3); exp_a.push_back(8'h0F);
    @(posedge clk); #1;
    bus_a.w = 1'b1; bus_a.d = 8'hA3; w0 = cyc;
    @(posedge clk); #1;
    bus_a.d = 8'h0F;
    @(posedge clk); #1;
    bus_a.w = 1'b0;
    wait_idle(0, 200, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL b2b_timeout: got busy line expected idle"); end
    n_cmp++; if (starts_a.size() != 2) begin
      n_err++; $display("FAIL b2b_starts: got %0d start bits expected 2", starts_a.size());
    end else begin
      n_cmp++; if (starts_a[0] != w0 + 2) begin n_err++; $display("FAIL b2b_latency: got %0d expected %0d", starts_a[0] - w0, 2); end
      n_cmp++; if (starts_a[1] - starts_a[0] != 40) begin n_err++; $display("FAIL b2b_spacing: got %0d expected 40", starts_a[1] - starts_a[0]); end
    end
    n_cmp++; if (rx_a.size() != exp_a.size()) begin n_err++; $display("FAIL b2b_count: got %0d frames expected %0d", rx_a.size(), exp_a.size()); end
    while (rx_a.size() > 0 && exp_a.size() > 0) begin
      g = rx_a.pop_front(); e = exp_a.pop_front();
      n_cmp++; if (g !== e) begin n_err++; $display("FAIL b2b_byte: got %h expected %h", g, e); end
    end
    rx_a.delete(); exp_a.delete();
  endtask

  task automatic test_overflow;
    logic [7:0] g;
    logic [7:0] e;
    bit         ok;
    @(posedge clk); #1;
    for (int n = 0; n <= 6; n++) begin
      bus_a.w = (n < 6);
      bus_a.d = 8'(n + 1);
      if (n < 5) exp_a.push_back(8'(n + 1));
      @(negedge clk);
      if (n >= 4) begin
        n_cmp++; if (bus_a.busy !== (n >= 5)) begin n_err++; $display("FAIL overflow_busy c%0d: got %b expected %b", n, bus_a.busy, (n >= 5)); end
      end
      @(posedge clk); #1;
    end
    bus_a.w = 1'b0;
    wait_idle(0, 400, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL overflow_timeout: got busy line expected idle"); end
    repeat (50) @(negedge clk);
    n_cmp++; if (rx_a.size() != exp_a.size()) begin n_err++; $display("FAIL overflow_count: got %0d frames expected %0d", rx_a.size(), exp_a.size()); end
    while (rx_a.size() > 0 && exp_a.size() > 0) begin
      g = rx_a.pop_front(); e = exp_a.pop_front();
      n_cmp++; if (g !== e) begin n_err++; $display("FAIL overflow_byte: got %h expected %h", g, e); end
    end
    rx_a.delete(); exp_a.delete();
  endtask

  task automatic test_simul;
    logic [7:0] vals [6] = '{8'h3C, 8'hC3, 8'h81, 8'h7E, 8'h42, 8'h24};
    logic [7:0] g;
    logic [7:0] e;
    int         k;
    bit         ok;
    k = 0;
    @(posedge clk); #1;
    for (int n = 0; n <= 44; n++) begin
      if (n <= 2 || (n >= 41 && n <= 43)) begin
        bus_a.w = 1'b1; bus_a.d = vals[k]; exp_a.push_back(vals[k]); k++;
      end else begin
        bus_a.w = 1'b0;
      end
      @(negedge clk);
      if (n == 41 || n == 42) begin
        n_cmp++; if (txd_a !== (n == 41)) begin n_err++; $display("FAIL simul_txd c%0d: got %b expected %b", n, txd_a, (n == 41)); end
      end
      if (n == 43 || n == 44) begin
        n_cmp++; if (bus_a.busy !== (n == 44)) begin n_err++; $display("FAIL simul_busy c%0d: got %b expected %b", n, bus_a.busy, (n == 44)); end
      end
      @(posedge clk); #1;
    end
    bus_a.w = 1'b0;
    wait_idle(0, 400, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL simul_timeout: got busy line expected idle"); end
    n_cmp++; if (rx_a.size() != exp_a.size()) begin n_err++; $display("FAIL simul_count: got %0d frames expected %0d", rx_a.size(), exp_a.size()); end
    while (rx_a.size() > 0 && exp_a.size() > 0) begin
      g = rx_a.pop_front(); e = exp_a.pop_front();
      n_cmp++; if (g !== e) begin n_err++; $display("FAIL simul_byte: got %h expected %h", g, e); end
    end
    rx_a.delete(); exp_a.delete();
  endtask

  task automatic test_reset_mid;
    int bad;
    starts_a.delete();
    @(posedge clk); #1;
    for (int n = 0; n < 20; n++) begin
      bus_a.w = (n < 4);
      bus_a.d = (n == 0) ? 8'hFF : 8'(n);
      if (n == 18) begin
        @(negedge clk);
        n_cmp++; if (txd_a !== 1'b1 || bus_a.idle !== 1'b0) begin n_err++; $display("FAIL rstmid_pre: got txd=%b idle=%b expected 1 0", txd_a, bus_a.idle); end
      end
      if (n == 19) rst = 1'b1;
      @(posedge clk); #1;
    end
    rst = 1'b0;
    bus_a.w = 1'b0;
    @(negedge clk);
    n_cmp++; if (txd_a !== 1'b1) begin n_err++; $display("FAIL rstmid_txd: got %b expected 1", txd_a); end
    n_cmp++; if (bus_a.busy !== 1'b0) begin n_err++; $display("FAIL rstmid_busy: got %b expected 0", bus_a.busy); end
    n_cmp++; if (bus_a.idle !== 1'b1) begin n_err++; $display("FAIL rstmid_idle: got %b expected 1", bus_a.idle); end
    bad = 0;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      if (txd_a !== 1'b1 || bus_a.idle !== 1'b1) bad++;
    end
    n_cmp++; if (bad != 0) begin n_err++; $display("FAIL rstmid_quiet: got %0d active cycles expected 0", bad); end
    n_cmp++; if (starts_a.size() != 1) begin n_err++; $display("FAIL rstmid_frames: got %0d start bits expected 1", starts_a.size()); end
    rx_a.delete(); exp_a.delete();
  endtask

  task automatic test_random;
    logic [7:0] g;
    logic [7:0] e;
    bit         ok;
    for (int i = 0; i < 10000; i++) begin
      @(posedge clk); #1;
      if (bus_b.busy === 1'b0 && $urandom_range(0, 7) == 0) begin
        bus_b.w = 1'b1; bus_b.d = 8'($urandom); exp_b.push_back(bus_b.d);
      end else begin
        bus_b.w = 1'b0;
      end
    end
    @(posedge clk); #1;
    bus_b.w = 1'b0;
    wait_idle(1, 2000, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL random_timeout: got busy line expected idle"); end
    repeat (30) @(negedge clk);
    n_cmp++; if (rx_b.size() != exp_b.size()) begin n_err++; $display("FAIL random_count: got %0d frames expected %0d", rx_b.size(), exp_b.size()); end
    while (rx_b.size() > 0 && exp_b.size() > 0) begin
      g = rx_b.pop_front(); e = exp_b.pop_front();
      n_cmp++; if (g !== e) begin n_err++; $display("FAIL random_byte: got %h expected %h", g, e); end
    end
    n_cmp++; if (frame_err != 0) begin n_err++; $display("FAIL framing: got %0d bad frames expected 0", frame_err); end
  endtask

  initial begin
    n_cmp = 0; n_err = 0; frame_err = 0;
    rst = 1'b1;
    bus_a.w = 1'b0; bus_a.d = 8'h00;
    bus_b.w = 1'b0; bus_b.d = 8'h00;
    fork
      rx_line(0, 4);
      rx_line(1, 2);
    join_none
    test_reset;
    test_single;
    test_back_to_back;
    test_overflow;
    test_simul;
    test_reset_mid;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
